// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter
//   Shares one AXI-style DDR read channel (AR + R) between two burst
//   requesters: IFM (input feature map) and WGT (weights). One burst is
//   in flight at a time. IDLE grants a requester, ADDR issues the address
//   beat, DATA steers the returned beats back to the granted requester.
//
//   Build option: define ARB_RR_EN to select round-robin arbitration
//   (the requester that did not finish last wins a tie). Without it,
//   IFM has fixed priority over WGT.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data beat width
//   LEN_W   burst length field width (beats minus one)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   ifm_req_* / wgt_req_*       burst request (addr, len, valid) / ready
//   ifm_r* / wgt_r*             returned beats (rdata, rvalid, rlast) / rready
//   m_axi_ar*                   shared read-address channel
//   m_axi_r*                    shared read-data channel
//   busy                        high whenever the FSM is not IDLE
//   dbg_state                   current FSM state (IDLE=0, ADDR=1, DATA=2)
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. A requester's ready depends
// combinationally on its valid; valid never depends on ready.

module dma_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifm_req_addr,
    input  logic [LEN_W-1:0]  ifm_req_len,
    input  logic              ifm_req_valid,
    output logic              ifm_req_ready,
    output logic [DATA_W-1:0] ifm_rdata,
    output logic              ifm_rvalid,
    output logic              ifm_rlast,
    input  logic              ifm_rready,

    input  logic [ADDR_W-1:0] wgt_req_addr,
    input  logic [LEN_W-1:0]  wgt_req_len,
    input  logic              wgt_req_valid,
    output logic              wgt_req_ready,
    output logic [DATA_W-1:0] wgt_rdata,
    output logic              wgt_rvalid,
    output logic              wgt_rlast,
    input  logic              wgt_rready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [LEN_W-1:0]  m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_grant_wgt;   // 0: IFM owns the burst, 1: WGT
`ifdef ARB_RR_EN
    logic              r_rr_wgt_first; // 1: WGT wins a simultaneous request
`endif

    logic w_idle;
    logic w_in_data;
    logic w_pick_wgt;
    logic w_accept;
    logic w_beat;
    logic w_last;

    // The FSM is cleared asynchronously, but IDLE alone would still let
    // req_ready follow req_valid while rst is held; gate it so every
    // output is 0 during reset.
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_in_data = (r_state == S_DATA);

`ifdef ARB_RR_EN
    assign w_pick_wgt = wgt_req_valid && (!ifm_req_valid || r_rr_wgt_first);
`else
    assign w_pick_wgt = wgt_req_valid && !ifm_req_valid;
`endif

    assign ifm_req_ready = w_idle && ifm_req_valid && !w_pick_wgt;
    assign wgt_req_ready = w_idle && w_pick_wgt;
    assign w_accept      = ifm_req_ready || wgt_req_ready;

    // Address channel: registered values, valid only in ADDR.
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arvalid = (r_state == S_ADDR);

    // Data channel: backpressure comes from the granted requester only.
    assign m_axi_rready = w_in_data && (r_grant_wgt ? wgt_rready : ifm_rready);
    assign w_beat       = m_axi_rvalid && m_axi_rready;
    assign w_last       = (r_beat_cnt == r_len);

    assign ifm_rvalid = w_in_data && !r_grant_wgt && m_axi_rvalid;
    assign wgt_rvalid = w_in_data &&  r_grant_wgt && m_axi_rvalid;
    assign ifm_rlast  = ifm_rvalid && w_last;
    assign wgt_rlast  = wgt_rvalid && w_last;
    assign ifm_rdata  = (w_in_data && !r_grant_wgt) ? m_axi_rdata : '0;
    assign wgt_rdata  = (w_in_data &&  r_grant_wgt) ? m_axi_rdata : '0;

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_len          <= '0;
            r_beat_cnt     <= '0;
            r_grant_wgt    <= 1'b0;
`ifdef ARB_RR_EN
            r_rr_wgt_first <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_accept) begin
                        r_grant_wgt <= w_pick_wgt;
                        r_addr      <= w_pick_wgt ? wgt_req_addr : ifm_req_addr;
                        r_len       <= w_pick_wgt ? wgt_req_len  : ifm_req_len;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_axi_arready) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (w_last) begin
                            // Leaving on the last beat keeps the counter
                            // from wrapping even when len is all ones.
                            r_beat_cnt <= '0;
                            r_state    <= S_IDLE;
`ifdef ARB_RR_EN
                            r_rr_wgt_first <= !r_grant_wgt;
`endif
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
